// File: rtl/mem_bus_responder.sv
// SRAM-style memory responder: one word transaction at a time, wait states, external ready.
// Optional BUS_TIMEOUT_EN macro adds a MEM_RDY timeout that completes the access with ERR.
module mem_bus_responder #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        REQ,
  input  logic        WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] WDATA,
  output logic [15:0] RDATA,
  output logic        ACK,
  output logic        ERR,
  output logic        BUSY,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_DOUT,
  input  logic [15:0] MEM_DIN,
  output logic        MEM_CEN,
  output logic        MEM_OEN,
  output logic        MEM_WEN,
  input  logic        MEM_RDY,
  output logic [1:0]  DBUSX
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_e;

  localparam logic [7:0] WS8 = 8'(WAIT_STATES);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] rdata_q, rdata_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        tmo_hit;

  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        cen_q, cen_d;
  logic        oen_q, oen_d;
  logic        wen_q, wen_d;
  logic [1:0]  dbusx_q, dbusx_d;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tcnt_q, tcnt_d;
  logic       err_q, err_d;

  // Fires on the stalled cycle in which the stall count reaches TIMEOUT.
  assign tmo_hit = (state_q == S_STROBE) && (wcnt_q == 8'd0) && !MEM_RDY &&
                   (tcnt_q == TMO_LAST);

  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q == S_SETUP)
      tcnt_d = 8'd0;
    else if (state_q == S_STROBE && wcnt_q == 8'd0 && !MEM_RDY && tcnt_q != 8'hFF)
      tcnt_d = tcnt_q + 8'd1;
  end

  assign err_d = (state_d == S_HOLD) && tmo_hit;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      tcnt_q <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign tmo_hit = 1'b0;
  assign ERR     = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (REQ) state_d = S_SETUP;
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: if (wcnt_q == 8'd0 && (MEM_RDY || tmo_hit)) state_d = S_HOLD;
      S_HOLD:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so nothing is combinational to a port.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    cen_d   = (state_d == S_IDLE);
    oen_d   = !(state_d == S_STROBE && !we_d);
    wen_d   = !(state_d == S_STROBE && we_d);
    ack_d   = (state_d == S_HOLD);
    dbusx_d = 2'd0;
    if (state_d != S_IDLE) dbusx_d = we_d ? 2'd1 : 2'd2;
  end

  // Request latch, wait counter and read capture
  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    wcnt_d  = wcnt_q;
    if (state_q == S_IDLE && REQ) begin
      we_d   = WE;
      addr_d = ADDR;
      if (WE) dout_d = WDATA;
    end
    if (state_q == S_SETUP)
      wcnt_d = WS8;
    else if (state_q == S_STROBE && wcnt_q != 8'd0)
      wcnt_d = wcnt_q - 8'd1;
    if (state_q == S_STROBE && state_d == S_HOLD && !we_q)
      rdata_d = tmo_hit ? 16'hFFFF : MEM_DIN;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      we_q    <= 1'b0;
      addr_q  <= 16'd0;
      dout_q  <= 16'd0;
      rdata_q <= 16'd0;
      wcnt_q  <= 8'd0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      cen_q   <= 1'b1;
      oen_q   <= 1'b1;
      wen_q   <= 1'b1;
      dbusx_q <= 2'd0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      wcnt_q  <= wcnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      cen_q   <= cen_d;
      oen_q   <= oen_d;
      wen_q   <= wen_d;
      dbusx_q <= dbusx_d;
    end
  end

  assign RDATA    = rdata_q;
  assign ACK      = ack_q;
  assign BUSY     = busy_q;
  assign MEM_ADDR = addr_q;
  assign MEM_DOUT = dout_q;
  assign MEM_CEN  = cen_q;
  assign MEM_OEN  = oen_q;
  assign MEM_WEN  = wen_q;
  assign DBUSX    = dbusx_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: vector table plus reset, back-to-back and timeout sequences.
module tb_mem_bus_responder;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        REQ, WE, MEM_RDY;
  logic [15:0] ADDR, WDATA, MEM_DIN;
  logic [15:0] RDATA, MEM_ADDR, MEM_DOUT;
  logic        ACK, ERR, BUSY, MEM_CEN, MEM_OEN, MEM_WEN;
  logic [1:0]  DBUSX;

  always #5 CLK = ~CLK;

  mem_bus_responder #(.WAIT_STATES(1), .TIMEOUT(15)) dut (
    .CLK(CLK), .RESETN(RESETN), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .RDATA(RDATA), .ACK(ACK), .ERR(ERR), .BUSY(BUSY), .MEM_ADDR(MEM_ADDR),
    .MEM_DOUT(MEM_DOUT), .MEM_DIN(MEM_DIN), .MEM_CEN(MEM_CEN), .MEM_OEN(MEM_OEN),
    .MEM_WEN(MEM_WEN), .MEM_RDY(MEM_RDY), .DBUSX(DBUSX)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] din;
    int          stall;
    int          lat;
    logic [15:0] rdata;
  } vec_t;

  // One full transaction; inputs are scrambled after acceptance to prove they are latched.
  task automatic run_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] din, input int stall,
                         output int lat, output int oen_n, output int wen_n, output int cen_n,
                         output logic [15:0] rd, output logic err_ack,
                         output logic bus_ok, output logic idle_ok);
    lat = 0; oen_n = 0; wen_n = 0; cen_n = 0; bus_ok = 1'b1; idle_ok = 1'b0;
    rd = 16'h0; err_ack = 1'b0;
    @(posedge CLK); #1;
    REQ = 1'b1; WE = we; ADDR = addr; WDATA = wdata; MEM_DIN = din; MEM_RDY = (stall == 0);
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(posedge CLK); #1;
      REQ = 1'b0; WE = ~we; ADDR = ~addr; WDATA = ~wdata;
      if (!MEM_OEN) oen_n++;
      if (!MEM_WEN) wen_n++;
      if (!MEM_CEN) cen_n++;
      if (!BUSY || DBUSX != (we ? 2'd1 : 2'd2) || MEM_ADDR != addr || (we && MEM_DOUT != wdata))
        bus_ok = 1'b0;
      if (ACK) begin
        lat = k; rd = RDATA; err_ack = ERR;
      end
      if (k == 3 + stall) MEM_RDY = 1'b1;
    end
    MEM_RDY = 1'b1;
    @(posedge CLK); #1;
    idle_ok = !ACK && !ERR && !BUSY && MEM_CEN && MEM_OEN && MEM_WEN && (DBUSX == 2'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int lat, oen_n, wen_n, cen_n;
    logic [15:0] rd;
    logic err_ack, bus_ok, idle_ok;
    int n_ack, last, gap_bad, addr_bad, rd_bad, acks_in_reset;
    logic prev_busy, txn_we;
    logic [15:0] acc_addr;

    vecs[0] = '{1'b0, 16'h0040, 16'h0000, 16'hA5C3, 0, 4, 16'hA5C3};
    vecs[1] = '{1'b1, 16'h1234, 16'hBEEF, 16'h0000, 0, 4, 16'hA5C3};
    vecs[2] = '{1'b0, 16'h0041, 16'h0000, 16'h5A3C, 3, 7, 16'h5A3C};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h0001, 16'h7777, 2, 6, 16'h5A3C};
    vecs[4] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 4, 16'h0000};
    vecs[5] = '{1'b0, 16'hFFFE, 16'h0000, 16'hFFFF, 1, 5, 16'hFFFF};

    RESETN = 1'b0; REQ = 1'b0; WE = 1'b0; ADDR = 16'h0; WDATA = 16'h0;
    MEM_DIN = 16'h0; MEM_RDY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rdata", RDATA, 16'h0);
    chk("rst_ack", ACK, 1'b0);
    chk("rst_err", ERR, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_addr", MEM_ADDR, 16'h0);
    chk("rst_dout", MEM_DOUT, 16'h0);
    chk("rst_dbusx", DBUSX, 2'd0);
    chk("rst_cen", MEM_CEN, 1'b1);
    chk("rst_oen", MEM_OEN, 1'b1);
    chk("rst_wen", MEM_WEN, 1'b1);
    RESETN = 1'b1;

    // Strobe lasts lat-2 cycles (everything except SETUP and HOLD); CEN is low for lat cycles.
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].din, vecs[i].stall,
              lat, oen_n, wen_n, cen_n, rd, err_ack, bus_ok, idle_ok);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
      chk($sformatf("v%0d_err", i), err_ack, 1'b0);
      chk($sformatf("v%0d_oen_cycles", i), oen_n, vecs[i].we ? 0 : vecs[i].lat - 2);
      chk($sformatf("v%0d_wen_cycles", i), wen_n, vecs[i].we ? vecs[i].lat - 2 : 0);
      chk($sformatf("v%0d_cen_cycles", i), cen_n, vecs[i].lat);
      chk($sformatf("v%0d_bus_ok", i), bus_ok, 1'b1);
      chk($sformatf("v%0d_idle_after", i), idle_ok, 1'b1);
    end

    // REQ held high, alternating read/write; ADDR changes every cycle.
    n_ack = 0; last = -1; gap_bad = 0; addr_bad = 0; rd_bad = 0;
    prev_busy = 1'b0; acc_addr = 16'h0; txn_we = 1'b0;
    @(posedge CLK); #1;
    REQ = 1'b1; WE = 1'b0; MEM_RDY = 1'b1; MEM_DIN = 16'hC0DE; ADDR = 16'h0100;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (BUSY && !prev_busy) begin
        acc_addr = ADDR;
        txn_we = WE;
      end
      if (BUSY && MEM_ADDR != acc_addr) addr_bad++;
      if (ACK) begin
        n_ack++;
        if (last >= 0 && k - last != 5) gap_bad++;
        last = k;
        if (!txn_we && RDATA != 16'hC0DE) rd_bad++;
        WE = ~WE;
      end
      prev_busy = BUSY;
      ADDR = 16'(k * 7 + 3);
    end
    REQ = 1'b0;
    chk("b2b_ack_count", n_ack, 8);
    chk("b2b_period_errors", gap_bad, 0);
    chk("b2b_addr_errors", addr_bad, 0);
    chk("b2b_rdata_errors", rd_bad, 0);
    repeat (2) @(posedge CLK);

    // Reset pulse during STROBE of a write.
    @(posedge CLK); #1;
    REQ = 1'b1; WE = 1'b1; ADDR = 16'h2222; WDATA = 16'h3333;
    @(posedge CLK); #1;
    REQ = 1'b0;
    @(posedge CLK); #1;
    chk("rstmid_wen_before", MEM_WEN, 1'b0);
    RESETN = 1'b0;
    #1;
    chk("rstmid_wen", MEM_WEN, 1'b1);
    chk("rstmid_cen", MEM_CEN, 1'b1);
    chk("rstmid_busy", BUSY, 1'b0);
    chk("rstmid_dbusx", DBUSX, 2'd0);
    acks_in_reset = 0;
    @(posedge CLK); #1;
    RESETN = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK); #1;
      if (ACK) acks_in_reset++;
    end
    chk("rstmid_no_ack", acks_in_reset, 0);
    run_txn(1'b0, 16'h0abc, 16'h0, 16'h1357, 0, lat, oen_n, wen_n, cen_n, rd, err_ack,
            bus_ok, idle_ok);
    chk("rstmid_retry_latency", lat, 4);
    chk("rstmid_retry_rdata", rd, 16'h1357);
    chk("rstmid_retry_idle", idle_ok, 1'b1);

`ifdef BUS_TIMEOUT_EN
    run_txn(1'b0, 16'h0100, 16'h0, 16'h1234, 1000, lat, oen_n, wen_n, cen_n, rd, err_ack,
            bus_ok, idle_ok);
    chk("tmo_latency", lat, 18);
    chk("tmo_err", err_ack, 1'b1);
    chk("tmo_rdata", rd, 16'hFFFF);
    chk("tmo_oen_cycles", oen_n, 16);
    chk("tmo_idle_after", idle_ok, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
